// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / branch-flush / memory-wait hazard controller for the 5-stage core
// Optional HAZARD_PERF_EN adds free-running stall/flush/wait event counters.
module hazard_stall_ctrl #(
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        rs1_used_ID,
  input  logic        rs2_used_ID,
  input  logic [4:0]  wr_EX,
  input  logic        we_EX,
  input  logic        mem_read_EX,
  input  logic        branch_taken_EX,
  input  logic        dmem_busy,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_stall,
  output logic        mem_wb_flush,
  output logic        mem_timeout,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_load_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_mem_wait,
`endif
  output logic [1:0]  hz_state
);

  localparam int BW = $clog2(LOAD_BUBBLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_LOAD     = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;

  generate
    if (LOAD_BUBBLES < 1) begin : g_bad_load_bubbles
      $error("hazard_stall_ctrl: LOAD_BUBBLES must be >= 1");
    end
    if (MEM_TIMEOUT < 1) begin : g_bad_mem_timeout
      $error("hazard_stall_ctrl: MEM_TIMEOUT must be >= 1");
    end
  endgenerate

  logic [1:0]    state, state_n;
  logic [1:0]    ret_state, ret_state_n;
  logic [BW-1:0] bub_cnt, bub_cnt_n;
  logic [WW-1:0] wait_cnt, wait_cnt_n;
  logic          timeout_q;

  logic          load_use;
  logic [1:0]    eff_state;
  logic          freeze;
  logic          load_stall;
  logic          br_flush;

  assign load_use = mem_read_EX & we_EX & (wr_EX != 5'd0) &
                    ((rs1_used_ID & (rs1_ID == wr_EX)) |
                     (rs2_used_ID & (rs2_ID == wr_EX)));

  // Leaving MEM_WAIT replays the rules of the state that was frozen.
  assign eff_state = (state == S_MEM_WAIT) ? ret_state : state;

  always_comb begin
    freeze      = 1'b0;
    load_stall  = 1'b0;
    br_flush    = 1'b0;
    state_n     = state;
    ret_state_n = ret_state;
    bub_cnt_n   = bub_cnt;
    wait_cnt_n  = wait_cnt;
    if (state == 2'd3) begin
      state_n = S_RUN;
    end else if (dmem_busy) begin
      freeze  = 1'b1;
      state_n = S_MEM_WAIT;
      if (state != S_MEM_WAIT) begin
        ret_state_n = state;
        wait_cnt_n  = WW'(1);
      end else if (wait_cnt != WW'(MEM_TIMEOUT)) begin
        wait_cnt_n = wait_cnt + WW'(1);
      end
    end else begin
      if (state == S_MEM_WAIT) begin
        wait_cnt_n = '0;
        state_n    = ret_state;
      end
      case (eff_state)
        S_RUN: begin
          state_n = S_RUN;
          if (branch_taken_EX) begin
            br_flush = 1'b1;
          end else if (load_use) begin
            load_stall = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              bub_cnt_n = BW'(LOAD_BUBBLES - 1);
              state_n   = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // EX holds a bubble here, so a taken branch cannot be real.
          load_stall = 1'b1;
          if (bub_cnt != '0) bub_cnt_n = bub_cnt - BW'(1);
          state_n = (bub_cnt <= BW'(1)) ? S_RUN : S_LOAD;
        end
        default: state_n = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      ret_state <= S_RUN;
      bub_cnt   <= '0;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      ret_state <= ret_state_n;
      bub_cnt   <= bub_cnt_n;
      wait_cnt  <= wait_cnt_n;
      if (state == S_MEM_WAIT && wait_cnt == WW'(MEM_TIMEOUT)) timeout_q <= 1'b1;
    end
  end

  // Gating with rst_n keeps every enable low while reset is held, whatever the inputs do.
  assign pc_stall     = rst_n & (freeze | load_stall);
  assign if_id_stall  = rst_n & (freeze | load_stall);
  assign if_id_flush  = rst_n & br_flush;
  assign id_ex_stall  = rst_n & freeze;
  assign id_ex_flush  = rst_n & (br_flush | load_stall);
  assign ex_mem_stall = rst_n & freeze;
  assign mem_wb_flush = rst_n & freeze;
  assign mem_timeout  = timeout_q;
  assign hz_state     = state;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_load_stall <= '0;
      perf_flush      <= '0;
      perf_mem_wait   <= '0;
    end else begin
      if (load_stall) perf_load_stall <= perf_load_stall + 32'd1;
      if (br_flush)   perf_flush      <= perf_flush + 32'd1;
      if (freeze)     perf_mem_wait   <= perf_mem_wait + 32'd1;
    end
  end
`endif

endmodule
